mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Parameters
REQ-001 The block SHALL have parameter WORD_W, default 8, giving the data word width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, giving the address width; the array depth is 2**ADDR_W words.
REQ-003 The block SHALL have parameter IO_ADDR, default 2**ADDR_W-1, giving the memory-mapped I/O location.

Interface
REQ-004 clock  input  1  sole clock; all state changes on the rising edge.
REQ-005 n_reset  input  1  reset; synchronous and active-low.
REQ-006 CS  input  1  chip select from the CPU sequencer; qualifies a one-cycle access.
REQ-007 R_NW  input  1  access direction when CS=1: 1 = read, 0 = write.
REQ-008 address  input  ADDR_W  word address (MAR contents).
REQ-009 wdata  input  WORD_W  write data (MDR contents).
REQ-010 rdata  output  WORD_W  registered read data, held until the next read completes.
REQ-011 rvalid  output  1  one-cycle pulse marking a freshly completed read.
REQ-012 ld_en  input  1  preload request from bench or boot loader.
REQ-013 ld_addr  input  ADDR_W  preload address.
REQ-014 ld_data  input  WORD_W  preload data.
REQ-015 ld_busy  output  1  high while in LOAD state.
REQ-016 io_in  input  WORD_W  external input port, read at IO_ADDR.
REQ-017 io_out  output  WORD_W  external output register, written at IO_ADDR.
REQ-018 ignored  output  1  sticky flag set when a CPU access is dropped during LOAD.

Function
REQ-019 The FSM SHALL have states RUN and LOAD; reset enters RUN.
REQ-020 RUN -> LOAD when ld_en=1; LOAD -> RUN on the first cycle with ld_en=0; LOAD writes nothing in that exit cycle.
REQ-021 In LOAD, every cycle with ld_en=1 SHALL write ld_data to mem[ld_addr], including the entry cycle, and ld_addr=IO_ADDR SHALL write the array, not io_out.
REQ-022 In RUN with CS=1, R_NW=1, the edge ending that cycle SHALL load rdata with mem[address] (or io_in when address=IO_ADDR), and rvalid=1 for exactly the following cycle; this matches the sequencer expecting data on the cycle after CS.
REQ-023 In RUN with CS=1, R_NW=0, the edge ending that cycle SHALL write wdata to mem[address], or to io_out when address=IO_ADDR; rdata is unchanged, rvalid=0.
REQ-024 Back-to-back CS cycles SHALL each complete independently; a read immediately after a write to the same address returns the new data.
REQ-025 Reads SHALL NOT modify the array; rdata holds its value across idle cycles.
REQ-026 In RUN, ld_en=1 and CS=1 in the same cycle: the CPU access SHALL complete, and the FSM enters LOAD at the same edge.
REQ-027 In LOAD, any CS=1 cycle SHALL be dropped (no write, no rdata update, rvalid=0) and SHALL set ignored=1.
REQ-028 Address wrap: all ADDR_W values SHALL be legal, with no out-of-range case.
REQ-029 ld_busy SHALL equal (state==LOAD), registered.

Reset
REQ-030 With n_reset=0 at a rising edge, the block SHALL set state=RUN, rdata=0, rvalid=0, io_out=0, ignored=0, and ld_busy=0.
REQ-031 Array contents SHALL be unaffected by reset, so a preloaded program survives a CPU reset.
REQ-032 Reset SHALL override any simultaneous CS or ld_en, and an access in that cycle SHALL NOT occur.
REQ-033 Reset mid-LOAD SHALL abort to RUN, keeping writes completed before the reset edge.

Verification
REQ-034 Preload: ld_en=1 for 3 cycles writing 0xA1, 0xB2, 0xC3 to addresses 0, 1, 2 -> ld_busy high for those cycles plus one, then low; CPU reads of addresses 0, 1, 2 return 0xA1, 0xB2, 0xC3.
REQ-035 Read timing: CS=1, R_NW=1, address=1 in cycle N -> rdata=0xB2 and rvalid=1 in cycle N+1, rvalid=0 in cycle N+2 with rdata still 0xB2.
REQ-036 Write-then-read: write 0x5A to address 7 in cycle N, read address 7 in cycle N+1 -> rdata=0x5A in cycle N+2.
REQ-037 I/O: write 0x3C to IO_ADDR -> io_out=0x3C; io_in=0x77 and read IO_ADDR -> rdata=0x77; a preload to IO_ADDR leaves io_out=0x3C.
REQ-038 Collision: during LOAD, CS=1, R_NW=0 to address 3 with 0xFF -> mem[3] unchanged and ignored=1 until reset; reset mid-LOAD -> ld_busy=0, rdata=0, array preserved.

Source files
------------

// File: rtl/mem_responder.sv
// Single-port word memory for a simple CPU sequencer, with a memory-mapped I/O
// location and a preload (LOAD) mode that locks out CPU accesses.
module mem_responder #(
  parameter int unsigned WORD_W  = 8,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned IO_ADDR = 2**ADDR_W - 1
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic              CS,
  input  logic              R_NW,
  input  logic [ADDR_W-1:0] address,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              rvalid,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [WORD_W-1:0] ld_data,
  output logic              ld_busy,
  input  logic [WORD_W-1:0] io_in,
  output logic [WORD_W-1:0] io_out,
  output logic              ignored
);

  typedef enum logic {RUN = 1'b0, LOAD = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] IO_LOC = ADDR_W'(IO_ADDR);

  state_t            state;
  logic [WORD_W-1:0] mem [2**ADDR_W];
  logic              cpu_rd;
  logic              cpu_wr;
  logic              hit_io;

  // CPU accesses are only honoured in RUN; in LOAD they are dropped and flagged.
  always_comb begin
    hit_io = (address == IO_LOC);
    cpu_rd = (state == RUN) && CS && R_NW;
    cpu_wr = (state == RUN) && CS && !R_NW;
  end

  // Array has no reset so a preloaded program survives a CPU reset.
  // The preload write is ordered last, so it wins an entry-cycle address clash.
  always_ff @(posedge clock) begin
    if (n_reset) begin
      if (cpu_wr && !hit_io) mem[address] <= wdata;
      if (ld_en)             mem[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      state   <= RUN;
      rdata   <= '0;
      rvalid  <= 1'b0;
      io_out  <= '0;
      ignored <= 1'b0;
      ld_busy <= 1'b0;
    end else begin
      rvalid <= cpu_rd;
      if (cpu_rd) rdata <= hit_io ? io_in : mem[address];
      if (cpu_wr && hit_io) io_out <= wdata;
      if ((state == LOAD) && CS) ignored <= 1'b1;
      case (state)
        RUN: begin
          if (ld_en) begin
            state   <= LOAD;
            ld_busy <= 1'b1;
          end
        end
        LOAD: begin
          if (!ld_en) begin
            state   <= RUN;
            ld_busy <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: read results go through a scoreboard
// queue, control/status outputs are checked inline per scenario.
module tb_mem_responder;

  localparam int unsigned WORD_W = 8;
  localparam int unsigned ADDR_W = 5;
  localparam logic [ADDR_W-1:0] IOA = 5'd31;

  logic              clock = 1'b0;
  logic              n_reset;
  logic              CS;
  logic              R_NW;
  logic [ADDR_W-1:0] address;
  logic [WORD_W-1:0] wdata;
  logic [WORD_W-1:0] rdata;
  logic              rvalid;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [WORD_W-1:0] ld_data;
  logic              ld_busy;
  logic [WORD_W-1:0] io_in;
  logic [WORD_W-1:0] io_out;
  logic              ignored;

  int vectors = 0;
  int errors  = 0;
  logic [WORD_W-1:0] exp_q[$];

  mem_responder #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .IO_ADDR(31)) dut (
    .clock(clock), .n_reset(n_reset), .CS(CS), .R_NW(R_NW),
    .address(address), .wdata(wdata), .rdata(rdata), .rvalid(rvalid),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_busy(ld_busy),
    .io_in(io_in), .io_out(io_out), .ignored(ignored)
  );

  always #5 clock = ~clock;

  // Scoreboard: every rvalid pulse must match the oldest outstanding read.
  always @(negedge clock) begin
    if (rvalid === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_rvalid: rdata=%h with no read outstanding", rdata);
      end else begin
        logic [WORD_W-1:0] e;
        e = exp_q.pop_front();
        if (rdata !== e) begin
          errors++;
          $display("FAIL read_data: got %h expected %h", rdata, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    CS = 1'b0; R_NW = 1'b1; ld_en = 1'b0;
  endtask

  task automatic test_reset();
    n_reset = 1'b0; idle();
    address = '0; wdata = '0; ld_addr = '0; ld_data = '0; io_in = '0;
    step(); step();
    vectors++;
    if ({rdata, rvalid, io_out, ignored, ld_busy} !== '0) begin
      errors++;
      $display("FAIL reset_state: rdata=%h rvalid=%b io_out=%h ignored=%b ld_busy=%b expected all 0",
               rdata, rvalid, io_out, ignored, ld_busy);
    end
    n_reset = 1'b1;
    step();
  endtask

  task automatic test_preload();
    logic [WORD_W-1:0] d [3];
    d[0] = 8'hA1; d[1] = 8'hB2; d[2] = 8'hC3;
    vectors++;
    if (ld_busy !== 1'b0) begin
      errors++; $display("FAIL busy_before_load: got %b expected 0", ld_busy);
    end
    for (int unsigned i = 0; i < 3; i++) begin
      ld_en = 1'b1; ld_addr = ADDR_W'(i); ld_data = d[i];
      step();
      vectors++;
      if (ld_busy !== 1'b1) begin
        errors++; $display("FAIL busy_during_load%0d: got %b expected 1", i, ld_busy);
      end
    end
    ld_en = 1'b0;
    step();
    vectors++;
    if (ld_busy !== 1'b0) begin
      errors++; $display("FAIL busy_after_load: got %b expected 0", ld_busy);
    end
    for (int unsigned i = 0; i < 3; i++) begin
      CS = 1'b1; R_NW = 1'b1; address = ADDR_W'(i);
      exp_q.push_back(d[i]);
      step();
    end
    idle(); step(); step();
  endtask

  task automatic test_read_timing();
    CS = 1'b1; R_NW = 1'b1; address = 5'd1;
    exp_q.push_back(8'hB2);
    step();
    idle();
    vectors++;
    if (rvalid !== 1'b1 || rdata !== 8'hB2) begin
      errors++; $display("FAIL read_n_plus_1: rvalid=%b rdata=%h expected 1/b2", rvalid, rdata);
    end
    step();
    vectors++;
    if (rvalid !== 1'b0 || rdata !== 8'hB2) begin
      errors++; $display("FAIL read_n_plus_2: rvalid=%b rdata=%h expected 0/b2", rvalid, rdata);
    end
    step();
  endtask

  task automatic test_back_to_back();
    CS = 1'b1; R_NW = 1'b0; address = 5'd7; wdata = 8'h5A;
    step();
    vectors++;
    if (rvalid !== 1'b0 || rdata !== 8'hB2) begin
      errors++; $display("FAIL write_keeps_rdata: rvalid=%b rdata=%h expected 0/b2", rvalid, rdata);
    end
    R_NW = 1'b1;
    exp_q.push_back(8'h5A);
    step();
    idle();
    vectors++;
    if (rdata !== 8'h5A) begin
      errors++; $display("FAIL write_then_read: got %h expected 5a", rdata);
    end
    // wrap-around extremes of the address space
    CS = 1'b1; R_NW = 1'b0; address = 5'd30; wdata = 8'h1E; step();
    address = 5'd0; wdata = 8'h0F; step();
    R_NW = 1'b1; address = 5'd30; exp_q.push_back(8'h1E); step();
    address = 5'd0; exp_q.push_back(8'h0F); step();
    R_NW = 1'b0; address = 5'd0; wdata = 8'hA1; step();
    idle(); step(); step();
  endtask

  task automatic test_io();
    CS = 1'b1; R_NW = 1'b0; address = IOA; wdata = 8'h3C;
    step();
    idle();
    vectors++;
    if (io_out !== 8'h3C) begin
      errors++; $display("FAIL io_write: got %h expected 3c", io_out);
    end
    io_in = 8'h77;
    CS = 1'b1; R_NW = 1'b1; address = IOA;
    exp_q.push_back(8'h77);
    step();
    idle();
    ld_en = 1'b1; ld_addr = IOA; ld_data = 8'hEE;
    step();
    ld_en = 1'b0;
    step();
    vectors++;
    if (io_out !== 8'h3C) begin
      errors++; $display("FAIL io_preload_untouched: got %h expected 3c", io_out);
    end
    step();
  endtask

  task automatic test_load_with_access();
    ld_en = 1'b1; ld_addr = 5'd10; ld_data = 8'hAA;
    CS = 1'b1; R_NW = 1'b1; address = 5'd1;
    exp_q.push_back(8'hB2);
    step();
    CS = 1'b0; ld_en = 1'b0;
    vectors++;
    if (ld_busy !== 1'b1 || ignored !== 1'b0) begin
      errors++; $display("FAIL load_entry_access: ld_busy=%b ignored=%b expected 1/0", ld_busy, ignored);
    end
    step();
    CS = 1'b1; R_NW = 1'b1; address = 5'd10;
    exp_q.push_back(8'hAA);
    step();
    idle(); step();
  endtask

  task automatic test_collision();
    ld_en = 1'b1; ld_addr = 5'd3; ld_data = 8'h33;
    step();
    ld_addr = 5'd5; ld_data = 8'h55;
    CS = 1'b1; R_NW = 1'b0; address = 5'd3; wdata = 8'hFF;
    step();
    R_NW = 1'b1; address = 5'd0;
    step();
    idle();
    vectors++;
    if (ignored !== 1'b1 || rvalid !== 1'b0) begin
      errors++; $display("FAIL collision_flag: ignored=%b rvalid=%b expected 1/0", ignored, rvalid);
    end
    step(); step();
    vectors++;
    if (ignored !== 1'b1) begin
      errors++; $display("FAIL ignored_sticky: got %b expected 1", ignored);
    end
    CS = 1'b1; R_NW = 1'b1; address = 5'd3; exp_q.push_back(8'h33); step();
    address = 5'd5; exp_q.push_back(8'h55); step();
    idle();
    // re-enter LOAD and reset in the middle of it
    ld_en = 1'b1; ld_addr = 5'd6; ld_data = 8'h66; step();
    ld_addr = 5'd8; ld_data = 8'h88; step();
    n_reset = 1'b0; ld_addr = 5'd2; ld_data = 8'h99;
    CS = 1'b1; R_NW = 1'b0; address = 5'd0; wdata = 8'h11;
    step();
    vectors++;
    if (ld_busy !== 1'b0 || rdata !== 8'h00 || ignored !== 1'b0 || io_out !== 8'h00) begin
      errors++; $display("FAIL reset_mid_load: ld_busy=%b rdata=%h ignored=%b io_out=%h expected 0/00/0/00",
                         ld_busy, rdata, ignored, io_out);
    end
    n_reset = 1'b1; idle();
    step();
    CS = 1'b1; R_NW = 1'b1;
    address = 5'd6; exp_q.push_back(8'h66); step();
    address = 5'd8; exp_q.push_back(8'h88); step();
    address = 5'd2; exp_q.push_back(8'hC3); step();
    address = 5'd0; exp_q.push_back(8'hA1); step();
    address = 5'd3; exp_q.push_back(8'h33); step();
    idle(); step(); step();
  endtask

  initial begin
    test_reset();
    test_preload();
    test_read_timing();
    test_back_to_back();
    test_io();
    test_load_with_access();
    test_collision();
    step();
    vectors++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL reads_outstanding: %0d reads never completed, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
